// File: rtl/tft_bus_arbiter_pkg.sv
// Shared definitions for the ILI9341 write-port arbiter: strobe FSM encodings,
// panel opcodes and the default frame size.
package tft_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SETUP = 2'b01,
        ST_WR_LO = 2'b11,
        ST_WR_HI = 2'b10
    } wr_state_t;

    localparam logic [7:0] CMD_RAMWR  = 8'h2C;
    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_DISPON = 8'h29;

    localparam int FRAME_PIXELS_DEFAULT = 76800;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tft_wr_strobe.sv
// Write-strobe sequencer: one start pulse produces SETUP, WR low and WR high
// phases, each lasting its parameterised number of cycles.
module tft_wr_strobe
    import tft_bus_arbiter_pkg::*;
#(
    parameter int SETUP_CYCLES   = 1,
    parameter int WR_LOW_CYCLES  = 1,
    parameter int WR_HIGH_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic wr_n,
    output logic idle
);

    localparam int CNT_MAX = max3(SETUP_CYCLES, WR_LOW_CYCLES, WR_HIGH_CYCLES);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] LOAD_SETUP = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_LO    = CNT_W'(WR_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_HI    = CNT_W'(WR_HIGH_CYCLES - 1);

    wr_state_t        state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;

    // wr_n is registered from next_state so the pin never sees a decode glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            wr_n  <= 1'b1;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            wr_n  <= (next_state != ST_WR_LO);
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_SETUP;
                    cnt_next   = LOAD_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    next_state = ST_WR_LO;
                    cnt_next   = LOAD_LO;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_WR_LO: begin
                if (cnt == '0) begin
                    next_state = ST_WR_HI;
                    cnt_next   = LOAD_HI;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_WR_HI: begin
                if (cnt == '0) begin
                    next_state = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign idle = (state == ST_IDLE);

endmodule

// File: rtl/tft_bus_arbiter.sv
// Arbitrates the ILI9341 8080 write port between command and pixel requesters,
// tracking the RAMWR window so pixels only land in GRAM while it is open.
module tft_bus_arbiter
    import tft_bus_arbiter_pkg::*;
#(
    parameter int SETUP_CYCLES   = 1,
    parameter int WR_LOW_CYCLES  = 1,
    parameter int WR_HIGH_CYCLES = 1,
    parameter int FRAME_PIXELS   = FRAME_PIXELS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic        cmd_rs,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        busy,
    output logic        mem_open,
    output logic        frame_done,
    output logic        screenRD,
    output logic        screenWR,
    output logic        screenRS,
    output logic [15:0] screenData
);

    localparam int             PCW      = $clog2(FRAME_PIXELS + 1);
    localparam logic [PCW-1:0] LAST_PIX = PCW'(FRAME_PIXELS - 1);

    logic           idle;
    logic           wr_n;
    logic           pix_last;
    logic           cmd_is_ramwr;
    logic [PCW-1:0] pix_cnt;

    // Commands always win; a pixel only goes out while the RAMWR window is open.
    assign cmd_ready    = idle && cmd_valid;
    assign pix_ready    = idle && !cmd_valid && pix_valid && mem_open;
    assign pix_last     = pix_ready && (pix_cnt == LAST_PIX);
    assign cmd_is_ramwr = !cmd_rs && (cmd_data[7:0] == CMD_RAMWR);

    tft_wr_strobe #(
        .SETUP_CYCLES   (SETUP_CYCLES),
        .WR_LOW_CYCLES  (WR_LOW_CYCLES),
        .WR_HIGH_CYCLES (WR_HIGH_CYCLES)
    ) u_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .start (cmd_ready || pix_ready),
        .wr_n  (wr_n),
        .idle  (idle)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            screenRS   <= 1'b1;
            screenData <= '0;
        end else if (cmd_ready) begin
            screenRS   <= cmd_rs;
            screenData <= cmd_data;
        end else if (pix_ready) begin
            screenRS   <= 1'b1;
            screenData <= pix_data;
        end
    end

    // Parameter writes (rs=1) leave the window alone; any other opcode closes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_open   <= 1'b0;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pix_last;
            if (cmd_ready) begin
                if (!cmd_rs) begin
                    mem_open <= cmd_is_ramwr;
                    if (cmd_is_ramwr) pix_cnt <= '0;
                end
            end else if (pix_ready) begin
                if (pix_last) begin
                    mem_open <= 1'b0;
                    pix_cnt  <= '0;
                end else begin
                    pix_cnt <= pix_cnt + PCW'(1);
                end
            end
        end
    end

    assign busy     = !idle;
    assign screenRD = 1'b1;
    assign screenWR = wr_n;

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Directed bench for tft_bus_arbiter: a default-timing instance with a 4-pixel
// frame and a slow-strobe instance for the stretched timing case.
module tb_tft_bus_arbiter;
    import tft_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_rs, pix_valid;
    logic [15:0] cmd_data, pix_data;
    logic        cmd_ready, pix_ready, busy, mem_open, frame_done;
    logic        screenRD, screenWR, screenRS;
    logic [15:0] screenData;

    logic        s_cmd_valid, s_cmd_rs, s_pix_valid;
    logic [15:0] s_cmd_data, s_pix_data;
    logic        s_cmd_ready, s_pix_ready, s_busy, s_mem_open, s_frame_done;
    logic        s_screenRD, s_screenWR, s_screenRS;
    logic [15:0] s_screenData;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tft_bus_arbiter #(
        .SETUP_CYCLES(1), .WR_LOW_CYCLES(1), .WR_HIGH_CYCLES(1), .FRAME_PIXELS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .busy(busy), .mem_open(mem_open), .frame_done(frame_done),
        .screenRD(screenRD), .screenWR(screenWR), .screenRS(screenRS), .screenData(screenData)
    );

    tft_bus_arbiter #(
        .SETUP_CYCLES(3), .WR_LOW_CYCLES(2), .WR_HIGH_CYCLES(2), .FRAME_PIXELS(4)
    ) dut_slow (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(s_cmd_valid), .cmd_rs(s_cmd_rs), .cmd_data(s_cmd_data), .cmd_ready(s_cmd_ready),
        .pix_valid(s_pix_valid), .pix_data(s_pix_data), .pix_ready(s_pix_ready),
        .busy(s_busy), .mem_open(s_mem_open), .frame_done(s_frame_done),
        .screenRD(s_screenRD), .screenWR(s_screenWR), .screenRS(s_screenRS), .screenData(s_screenData)
    );

    task automatic do_cmd(input logic rs, input logic [15:0] d, output bit timeout);
        timeout = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin timeout = 1'b0; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_pix(input logic [15:0] d, output bit timeout);
        timeout = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b1; pix_data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pix_ready === 1'b1) begin timeout = 1'b0; break; end
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin timeout = 1'b0; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cmd_valid = 0; cmd_rs = 0; cmd_data = '0; pix_valid = 0; pix_data = '0;
        s_cmd_valid = 0; s_cmd_rs = 0; s_cmd_data = '0; s_pix_valid = 0; s_pix_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (screenWR !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_wr: got %b expected 1", screenWR); end
        vectors++; if (screenRS !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_rs: got %b expected 1", screenRS); end
        vectors++; if (screenData !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_data: got %h expected 0000", screenData); end
        vectors++; if ({busy, mem_open, frame_done} !== 3'b000) begin miscompares++; $display("[TB] FAIL rst_flags: got %b expected 000", {busy, mem_open, frame_done}); end
        vectors++; if (screenRD !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_rd: got %b expected 1", screenRD); end
        vectors++; if (s_screenWR !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_slow_wr: got %b expected 1", s_screenWR); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cmd_timing(input string tag);
        bit to;
        logic exp_wr, exp_rdy, exp_busy;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = {8'h00, CMD_SLPOUT};
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_accept: got %b expected 1", tag, cmd_ready); end
        @(posedge clk); #1;
        cmd_data = {8'h00, CMD_DISPON};
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_wr   = (k == 2) ? 1'b0 : 1'b1;
            exp_rdy  = (k == 4);
            exp_busy = (k < 4);
            vectors++; if (screenWR !== exp_wr) begin miscompares++; $display("[TB] FAIL %s_wr_n%0d: got %b expected %b", tag, k, screenWR, exp_wr); end
            vectors++; if (cmd_ready !== exp_rdy) begin miscompares++; $display("[TB] FAIL %s_ready_n%0d: got %b expected %b", tag, k, cmd_ready, exp_rdy); end
            vectors++; if (busy !== exp_busy) begin miscompares++; $display("[TB] FAIL %s_busy_n%0d: got %b expected %b", tag, k, busy, exp_busy); end
            if (k < 4) begin
                vectors++; if ({screenRS, screenData} !== {1'b0, 16'h0011}) begin miscompares++; $display("[TB] FAIL %s_bus_n%0d: got %b/%h expected 0/0011", tag, k, screenRS, screenData); end
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle(to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_idle_timeout: got %b expected 0", tag, to); end
        vectors++; if (mem_open !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_mem_open: got %b expected 0", tag, mem_open); end
    endtask

    task automatic test_pix_stall;
        int seen_ready, seen_wr;
        seen_ready = 0; seen_wr = 0;
        @(posedge clk); #1;
        pix_valid = 1'b1; pix_data = 16'hBEEF;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pix_ready !== 1'b0) seen_ready++;
            if (screenWR !== 1'b1) seen_wr++;
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        vectors++; if (seen_ready != 0) begin miscompares++; $display("[TB] FAIL stall_ready: got %0d ready cycles expected 0", seen_ready); end
        vectors++; if (seen_wr != 0) begin miscompares++; $display("[TB] FAIL stall_strobes: got %0d wr-low cycles expected 0", seen_wr); end
    endtask

    task automatic test_frame;
        bit to, to2;
        int acc, strobes, bad, fd, fd_cyc, acc4_cyc;
        logic prev_wr;
        acc = 0; strobes = 0; bad = 0; fd = 0; fd_cyc = -1; acc4_cyc = -1; prev_wr = 1'b1;
        do_cmd(1'b0, {8'h00, CMD_RAMWR}, to);
        wait_idle(to2);
        vectors++; if ((to | to2) !== 1'b0) begin miscompares++; $display("[TB] FAIL frame_open_timeout: got 1 expected 0"); end
        vectors++; if (mem_open !== 1'b1) begin miscompares++; $display("[TB] FAIL frame_open: got %b expected 1", mem_open); end
        @(posedge clk); #1;
        pix_valid = 1'b1; pix_data = 16'hA000;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pix_ready === 1'b1) begin acc++; if (acc == 4) acc4_cyc = i; end
            if (frame_done === 1'b1) begin fd++; fd_cyc = i; end
            if (screenWR === 1'b0 && prev_wr === 1'b1) begin
                if (screenRS !== 1'b1) bad++;
                if (screenData !== 16'(16'hA000 + strobes)) bad++;
                strobes++;
            end
            prev_wr = screenWR;
            @(posedge clk); #1;
            pix_data = 16'(16'hA000 + acc);
        end
        vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL frame_5th_stall: got %b expected 0", pix_ready); end
        pix_valid = 1'b0;
        vectors++; if (acc != 4) begin miscompares++; $display("[TB] FAIL frame_accepts: got %0d expected 4", acc); end
        vectors++; if (strobes != 4) begin miscompares++; $display("[TB] FAIL frame_strobes: got %0d expected 4", strobes); end
        vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL frame_strobe_bus: got %0d bad strobes expected 0", bad); end
        vectors++; if (fd != 1) begin miscompares++; $display("[TB] FAIL frame_done_count: got %0d expected 1", fd); end
        vectors++; if (fd_cyc != acc4_cyc + 1) begin miscompares++; $display("[TB] FAIL frame_done_cycle: got %0d expected %0d", fd_cyc, acc4_cyc + 1); end
        vectors++; if (mem_open !== 1'b0) begin miscompares++; $display("[TB] FAIL frame_closed: got %b expected 0", mem_open); end
    endtask

    task automatic test_arbitration;
        bit to, to2, to_any;
        int pr_early, pr_late;
        to_any = 1'b0; pr_early = 0; pr_late = 0;
        do_cmd(1'b0, {8'h00, CMD_RAMWR}, to); to_any |= to;
        wait_idle(to2); to_any |= to2;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 16'h1234;
        pix_valid = 1'b1; pix_data = 16'h5555;
        @(negedge clk);
        vectors++; if ({cmd_ready, pix_ready} !== 2'b10) begin miscompares++; $display("[TB] FAIL arb_both: got %b expected 10", {cmd_ready, pix_ready}); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (pix_ready !== 1'b0) pr_early++;
        end
        @(negedge clk);
        vectors++; if (pr_early != 0) begin miscompares++; $display("[TB] FAIL arb_pix_early: got %0d expected 0", pr_early); end
        vectors++; if (pix_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL arb_pix_slot: got %b expected 1", pix_ready); end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        wait_idle(to); to_any |= to;
        vectors++; if ({screenRS, screenData} !== {1'b1, 16'h5555}) begin miscompares++; $display("[TB] FAIL arb_pix_bus: got %b/%h expected 1/5555", screenRS, screenData); end
        vectors++; if (mem_open !== 1'b1) begin miscompares++; $display("[TB] FAIL arb_param_keeps_open: got %b expected 1", mem_open); end

        // RAMWR while already open must restart the count from zero.
        do_cmd(1'b0, {8'h00, CMD_RAMWR}, to); to_any |= to;
        for (int i = 0; i < 4; i++) begin
            do_pix(16'(16'hC000 + i), to); to_any |= to;
            @(negedge clk);
            vectors++; if (frame_done !== (i == 3)) begin miscompares++; $display("[TB] FAIL restart_done_%0d: got %b expected %b", i, frame_done, (i == 3)); end
        end
        vectors++; if (mem_open !== 1'b0) begin miscompares++; $display("[TB] FAIL restart_closed: got %b expected 0", mem_open); end

        do_cmd(1'b0, {8'h00, CMD_RAMWR}, to); to_any |= to;
        wait_idle(to2); to_any |= to2;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 16'h002A;
        pix_valid = 1'b1; pix_data = 16'h7777;
        @(negedge clk);
        vectors++; if ({cmd_ready, pix_ready} !== 2'b10) begin miscompares++; $display("[TB] FAIL arb_close_both: got %b expected 10", {cmd_ready, pix_ready}); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_ready !== 1'b0) pr_late++;
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        vectors++; if (pr_late != 0) begin miscompares++; $display("[TB] FAIL arb_close_stall: got %0d ready cycles expected 0", pr_late); end
        vectors++; if (mem_open !== 1'b0) begin miscompares++; $display("[TB] FAIL arb_close_mem: got %b expected 0", mem_open); end
        vectors++; if (to_any !== 1'b0) begin miscompares++; $display("[TB] FAIL arb_timeout: got 1 expected 0"); end
    endtask

    task automatic test_reset_mid_write;
        bit to, to2;
        do_cmd(1'b0, {8'h00, CMD_RAMWR}, to);
        wait_idle(to2);
        vectors++; if ((to | to2) !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_timeout: got 1 expected 0"); end
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 16'hABCD;
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_accept: got %b expected 1", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        vectors++; if (screenWR !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_wr_lo: got %b expected 0", screenWR); end
        rst_n = 1'b0;
        #1;
        vectors++; if (screenWR !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_wr: got %b expected 1", screenWR); end
        vectors++; if ({screenRS, screenData} !== {1'b1, 16'h0000}) begin miscompares++; $display("[TB] FAIL midrst_bus: got %b/%h expected 1/0000", screenRS, screenData); end
        vectors++; if ({busy, mem_open, frame_done} !== 3'b000) begin miscompares++; $display("[TB] FAIL midrst_flags: got %b expected 000", {busy, mem_open, frame_done}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_cmd_timing("post_rst");
    endtask

    task automatic test_slow_timing;
        logic exp_wr, exp_rdy;
        @(posedge clk); #1;
        s_cmd_valid = 1'b1; s_cmd_rs = 1'b0; s_cmd_data = 16'h0011;
        @(negedge clk);
        vectors++; if (s_cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL slow_accept: got %b expected 1", s_cmd_ready); end
        @(posedge clk); #1;
        s_cmd_data = 16'h0029;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_wr  = (k == 4 || k == 5) ? 1'b0 : 1'b1;
            exp_rdy = (k == 8);
            vectors++; if (s_screenWR !== exp_wr) begin miscompares++; $display("[TB] FAIL slow_wr_n%0d: got %b expected %b", k, s_screenWR, exp_wr); end
            vectors++; if (s_cmd_ready !== exp_rdy) begin miscompares++; $display("[TB] FAIL slow_ready_n%0d: got %b expected %b", k, s_cmd_ready, exp_rdy); end
            if (k == 1) begin
                vectors++; if ({s_screenRS, s_screenData} !== {1'b0, 16'h0011}) begin miscompares++; $display("[TB] FAIL slow_bus: got %b/%h expected 0/0011", s_screenRS, s_screenData); end
            end
        end
        @(posedge clk); #1;
        s_cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_cmd_timing("single");
        test_pix_stall();
        test_frame();
        test_arbitration();
        test_reset_mid_write();
        test_slow_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
